multicycle_controller: RTL

//  Multi-cycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback around the shared ALU execute stage.

---
 rtl/multicycle_controller_pkg.sv | 50 +++++
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/multicycle_controller_insn_classifier.sv | 38 +++
 rtl/multicycle_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, instruction
// classes, opcode/funct values and ALU / PC-source selects.
package multicycle_controller_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERR    = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        CL_RALU    = 4'd0,
        CL_IALU    = 4'd1,
        CL_LW      = 4'd2,
        CL_SW      = 4'd3,
        CL_BR      = 4'd4,
        CL_J       = 4'd5,
        CL_JAL     = 4'd6,
        CL_JR      = 4'd7,
        CL_ILLEGAL = 4'd8
    } insn_class_e;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [2:0] OP_IALU_GRP = 3'b001;
    localparam logic [5:0] FN_JR       = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    // Shift-family R-type instructions have funct[5:3] == 000.
    function automatic logic is_shift(input logic [5:0] funct);
        return (funct[5:3] == 3'b000);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the control FSM and the datapath it steers.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [31:0] instruction;
    logic        mem_ready;
    logic        zero;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        reg_dst;
    logic        jal;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        sftmd;
    logic        i_format;
    logic [2:0]  state;
    logic        instr_done;
    logic        error;

    modport master (
        input  instruction, mem_ready, zero,
        output pc_write, pc_src, ir_write, mem_read, mem_write, mem_to_reg,
               reg_write, reg_dst, jal, alu_op, alu_src, sftmd, i_format,
               state, instr_done, error
    );

    modport slave (
        output instruction, mem_ready, zero,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, mem_to_reg,
               reg_write, reg_dst, jal, alu_op, alu_src, sftmd, i_format,
               state, instr_done, error
    );
endinterface

// File: rtl/multicycle_controller_insn_classifier.sv
// Combinational opcode/funct decoder producing the instruction class that
// steers the control FSM. Unknown opcodes map to CL_ILLEGAL.
module insn_classifier
    import multicycle_controller_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    output insn_class_e insn_class_o
);

    // Map opcode (and funct for R-type) onto an instruction class.
    always_comb begin
        insn_class_o = CL_ILLEGAL;
        case (opcode_i)
            OP_RTYPE: begin
                if (funct_i == FN_JR) begin
                    insn_class_o = CL_JR;
                end else begin
                    insn_class_o = CL_RALU;
                end
            end
            OP_LW:  insn_class_o = CL_LW;
            OP_SW:  insn_class_o = CL_SW;
            OP_BEQ: insn_class_o = CL_BR;
            OP_BNE: insn_class_o = CL_BR;
            OP_J:   insn_class_o = CL_J;
            OP_JAL: insn_class_o = CL_JAL;
            default: begin
                if (opcode_i[5:3] == OP_IALU_GRP) begin
                    insn_class_o = CL_IALU;
                end else begin
                    insn_class_o = CL_ILLEGAL;
                end
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Outputs are decoded from the current state and the opcode/funct captured in
// DECODE; memory waits are bounded by TIMEOUT cycles, after which the FSM parks
// in ERR until reset. TIMEOUT must be at least 2.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    multicycle_controller_if.master bus
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [5:0]        funct_q, funct_d;
    insn_class_e       cls_s;
    logic              tmo_hit_s;
    logic              unused_s;

    logic              pc_write_s, ir_write_s, mem_read_s, mem_write_s;
    logic              mem_to_reg_s, reg_write_s, reg_dst_s, jal_s;
    logic              alu_src_s, sftmd_s, i_format_s, instr_done_s, error_s;
    logic [1:0]        pc_src_s, alu_op_s;
    logic [2:0]        state_out_s;

    // In DECODE the class comes straight from the IR; afterwards from the latched copy.
    assign opcode_d  = (state_q == ST_DECODE) ? bus.instruction[31:26] : opcode_q;
    assign funct_d   = (state_q == ST_DECODE) ? bus.instruction[5:0]   : funct_q;
    assign tmo_hit_s = (tmo_cnt_q == TMO_LAST);
    assign unused_s  = ^bus.instruction[25:6];

    insn_classifier u_classifier (
        .opcode_i     (opcode_d),
        .funct_i      (funct_d),
        .insn_class_o (cls_s)
    );

    // State register, memory-wait counter and latched instruction fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            tmo_cnt_q <= '0;
            opcode_q  <= 6'd0;
            funct_q   <= 6'd0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
        end
    end

    // Next state, wait counter and control strobes; all outputs low during reset.
    always_comb begin
        state_d      = state_q;
        tmo_cnt_d    = '0;
        pc_write_s   = 1'b0;
        pc_src_s     = PC_SEQ;
        ir_write_s   = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        reg_dst_s    = 1'b0;
        jal_s        = 1'b0;
        alu_op_s     = ALU_ADD;
        alu_src_s    = 1'b0;
        sftmd_s      = 1'b0;
        i_format_s   = 1'b0;
        instr_done_s = 1'b0;
        error_s      = 1'b0;
        state_out_s  = 3'd0;
        if (reset) begin
            state_d = ST_FETCH;
        end else begin
            state_out_s = state_q;
            case (state_q)
                ST_FETCH: begin
                    mem_read_s = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write_s = 1'b1;
                        pc_write_s = 1'b1;
                        pc_src_s   = PC_SEQ;
                        state_d    = ST_DECODE;
                    end else if (tmo_hit_s) begin
                        state_d = ST_ERR;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                    end
                end
                ST_DECODE: begin
                    if (cls_s == CL_ILLEGAL) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (cls_s)
                        CL_RALU: begin
                            alu_op_s = ALU_FUNCT;
                            sftmd_s  = is_shift(funct_q);
                            state_d  = ST_WB;
                        end
                        CL_IALU: begin
                            alu_op_s   = ALU_FUNCT;
                            alu_src_s  = 1'b1;
                            i_format_s = 1'b1;
                            state_d    = ST_WB;
                        end
                        CL_LW, CL_SW: begin
                            alu_op_s  = ALU_ADD;
                            alu_src_s = 1'b1;
                            state_d   = ST_MEM;
                        end
                        CL_BR: begin
                            // opcode bit 0 distinguishes bne (taken on !zero) from beq.
                            alu_op_s     = ALU_SUB;
                            pc_src_s     = PC_BRANCH;
                            pc_write_s   = opcode_q[0] ? ~bus.zero : bus.zero;
                            instr_done_s = 1'b1;
                            state_d      = ST_FETCH;
                        end
                        CL_J: begin
                            pc_write_s   = 1'b1;
                            pc_src_s     = PC_JUMP;
                            instr_done_s = 1'b1;
                            state_d      = ST_FETCH;
                        end
                        CL_JAL: begin
                            pc_write_s   = 1'b1;
                            pc_src_s     = PC_JUMP;
                            reg_write_s  = 1'b1;
                            jal_s        = 1'b1;
                            instr_done_s = 1'b1;
                            state_d      = ST_FETCH;
                        end
                        CL_JR: begin
                            pc_write_s   = 1'b1;
                            pc_src_s     = PC_REG;
                            instr_done_s = 1'b1;
                            state_d      = ST_FETCH;
                        end
                        default: state_d = ST_ERR;
                    endcase
                end
                ST_MEM: begin
                    if (cls_s == CL_SW) begin
                        mem_write_s = 1'b1;
                    end else begin
                        mem_read_s = 1'b1;
                    end
                    if (bus.mem_ready) begin
                        if (cls_s == CL_SW) begin
                            instr_done_s = 1'b1;
                            state_d      = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end else if (tmo_hit_s) begin
                        state_d = ST_ERR;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                    end
                end
                ST_WB: begin
                    reg_write_s  = 1'b1;
                    reg_dst_s    = (cls_s == CL_RALU);
                    mem_to_reg_s = (cls_s == CL_LW);
                    instr_done_s = 1'b1;
                    state_d      = ST_FETCH;
                end
                ST_ERR: begin
                    error_s = 1'b1;
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_ERR;
                end
            endcase
        end
    end

    assign bus.pc_write   = pc_write_s;
    assign bus.pc_src     = pc_src_s;
    assign bus.ir_write   = ir_write_s;
    assign bus.mem_read   = mem_read_s;
    assign bus.mem_write  = mem_write_s;
    assign bus.mem_to_reg = mem_to_reg_s;
    assign bus.reg_write  = reg_write_s;
    assign bus.reg_dst    = reg_dst_s;
    assign bus.jal        = jal_s;
    assign bus.alu_op     = alu_op_s;
    assign bus.alu_src    = alu_src_s;
    assign bus.sftmd      = sftmd_s;
    assign bus.i_format   = i_format_s;
    assign bus.state      = state_out_s;
    assign bus.instr_done = instr_done_s;
    assign bus.error      = error_s;

endmodule
